// File: rtl/demux_lane_deserializer.sv
// Four-lane deserializer behind a 1-to-4 demultiplexer.
// Each lane packs MSB-first bits into WIDTH-bit words and offers them over valid/ready.
module demux_lane_deserializer #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               strb,
   input  logic [1:0]         S,
   input  logic [3:0]         Y,
   input  logic               flush,
   input  logic [3:0]         word_ready,
   output logic [3:0]         word_valid,
   output logic [4*WIDTH-1:0] word,
   output logic [3:0]         overrun,
   output logic               sel_err
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {EMPTY, FULL} out_state_t;

   out_state_t       state      [4];
   out_state_t       state_next [4];
   // Only WIDTH-1 bits are kept: the final bit of a word comes straight from Y.
   logic [WIDTH-2:0] sh         [4];
   logic [CW-1:0]    cnt        [4];
   logic [WIDTH-1:0] word_r     [4];
   logic [WIDTH-1:0] new_word   [4];
   logic [3:0]       capture;
   logic [3:0]       complete;
   logic [3:0]       load;
   logic [3:0]       drop;
   logic             stray;

   always_comb begin
      capture  = '0;
      complete = '0;
      load     = '0;
      drop     = '0;
      stray    = strb && ((Y & ~(4'b0001 << S)) != 4'b0000);
      for (int k = 0; k < 4; k++) begin
         state_next[k] = state[k];
         new_word[k]   = {sh[k], Y[k]};
         capture[k]    = strb && !flush && (S == 2'(k));
         complete[k]   = capture[k] && (cnt[k] == LAST);
         case (state[k])
            EMPTY: begin
               if (complete[k]) begin
                  state_next[k] = FULL;
                  load[k]       = 1'b1;
               end
            end
            FULL: begin
               if (complete[k] && word_ready[k]) begin
                  load[k] = 1'b1;
               end else if (complete[k]) begin
                  drop[k] = 1'b1;
               end else if (word_ready[k]) begin
                  state_next[k] = EMPTY;
               end
            end
            default: state_next[k] = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            state[k] <= EMPTY;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            state[k] <= state_next[k];
         end
      end
   end

   // Flush wins over a same-cycle strobe, so that bit never reaches the shifter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            sh[k]     <= '0;
            cnt[k]    <= '0;
            word_r[k] <= '0;
         end
         overrun <= '0;
         sel_err <= 1'b0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (flush) begin
               cnt[k] <= '0;
            end else if (capture[k]) begin
               sh[k]  <= new_word[k][WIDTH-2:0];
               cnt[k] <= complete[k] ? '0 : cnt[k] + 1'b1;
            end
            if (load[k]) begin
               word_r[k] <= new_word[k];
            end
            if (flush) begin
               overrun[k] <= 1'b0;
            end else if (drop[k]) begin
               overrun[k] <= 1'b1;
            end
         end
         if (flush) begin
            sel_err <= 1'b0;
         end else if (stray) begin
            sel_err <= 1'b1;
         end
      end
   end

   always_comb begin
      word_valid = '0;
      word       = '0;
      for (int k = 0; k < 4; k++) begin
         word_valid[k]             = (state[k] == FULL);
         word[k*WIDTH +: WIDTH]    = word_r[k];
      end
   end

endmodule

// File: tb/tb_demux_lane_deserializer.sv
// Self-checking bench for demux_lane_deserializer (WIDTH=8): directed scenarios
// followed by random traffic, compared each cycle against a bit-counting lane model.
module tb_demux_lane_deserializer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        strb = 1'b0;
   logic [1:0]  S = '0;
   logic [3:0]  Y = '0;
   logic        flush = 1'b0;
   logic [3:0]  word_ready = '0;
   logic [3:0]  word_valid;
   logic [31:0] word;
   logic [3:0]  overrun;
   logic        sel_err;

   int compared = 0;
   int mismatched = 0;

   int         m_cnt  [4];
   int         m_acc  [4];
   logic [7:0] m_word [4];
   logic [3:0] m_valid;
   logic [3:0] m_ovr;
   logic       m_sel;

   demux_lane_deserializer #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .strb(strb), .S(S), .Y(Y), .flush(flush),
      .word_ready(word_ready), .word_valid(word_valid), .word(word),
      .overrun(overrun), .sel_err(sel_err)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int k = 0; k < 4; k++) begin
         m_cnt[k]  = 0;
         m_acc[k]  = 0;
         m_word[k] = 8'h00;
      end
      m_valid = '0;
      m_ovr   = '0;
      m_sel   = 1'b0;
   endfunction

   // Lane words are built arithmetically: each new bit doubles the running value.
   function automatic void model_step();
      int done = -1;
      int cw = 0;
      int ln = int'(S);
      if (flush) begin
         for (int k = 0; k < 4; k++) begin
            m_cnt[k] = 0;
            m_acc[k] = 0;
         end
         m_ovr = '0;
         m_sel = 1'b0;
      end else if (strb) begin
         for (int j = 0; j < 4; j++) begin
            if (j != ln && Y[j]) m_sel = 1'b1;
         end
         m_acc[ln] = m_acc[ln] * 2 + int'(Y[ln]);
         m_cnt[ln] = m_cnt[ln] + 1;
         if (m_cnt[ln] == 8) begin
            done      = ln;
            cw        = m_acc[ln] % 256;
            m_cnt[ln] = 0;
            m_acc[ln] = 0;
         end
      end
      for (int k = 0; k < 4; k++) begin
         if (m_valid[k]) begin
            if (done == k) begin
               if (word_ready[k]) m_word[k] = cw[7:0];
               else m_ovr[k] = 1'b1;
            end else if (word_ready[k]) begin
               m_valid[k] = 1'b0;
            end
         end else if (done == k) begin
            m_valid[k] = 1'b1;
            m_word[k]  = cw[7:0];
         end
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      check({tag, ".valid"}, 32'(word_valid), 32'(m_valid));
      check({tag, ".word"}, word, {m_word[3], m_word[2], m_word[1], m_word[0]});
      check({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
      check({tag, ".sel_err"}, 32'(sel_err), 32'(m_sel));
   endtask

   task automatic applyStimulus(input logic st, input logic [1:0] s, input logic [3:0] y,
                                input logic fl, input logic [3:0] rdy, input string tag);
      strb       = st;
      S          = s;
      Y          = y;
      flush      = fl;
      word_ready = rdy;
      @(posedge clk);
      model_step();
      #1;
      checkOutput(tag);
   endtask

   task automatic strobe(input logic [1:0] s, input logic b, input logic [3:0] rdy, input string tag);
      applyStimulus(1'b1, s, 4'(b) << s, 1'b0, rdy, tag);
   endtask

   task automatic sendWord(input logic [1:0] s, input logic [7:0] w, input logic [3:0] last_rdy,
                           input string tag);
      for (int i = 7; i >= 0; i--) begin
         strobe(s, w[i], (i == 0) ? last_rdy : 4'b0000, tag);
      end
   endtask

   initial begin
      logic [7:0] pat;
      model_reset();
      #12 rst_n = 1'b1;

      // Build up some state, then reset asynchronously between edges.
      sendWord(2'd3, 8'h5A, 4'b0000, "pre");
      for (int i = 0; i < 3; i++) strobe(2'd0, 1'b1, 4'b0000, "pre_part");
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      checkOutput("async_rst");
      check("async_rst.word_const", word, 32'h0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 2'($urandom), 4'($urandom), 1'b0, 4'b0000, "idle");
      end

      // Single lane, MSB first: 1,0,1,1,0,0,1,0 = 0xB2.
      pat = 8'hB2;
      sendWord(2'd1, pat, 4'b0000, "single");
      check("single.valid_const", 32'(word_valid), 32'h2);
      check("single.byte_const", 32'(word[15:8]), 32'hB2);
      applyStimulus(1'b0, 2'd0, 4'h0, 1'b0, 4'b0010, "single_drain");
      check("single.drained", 32'(word_valid[1]), 32'h0);

      // Round-robin, lane k carries constant bit (k odd).
      for (int i = 0; i < 32; i++) begin
         strobe(2'(i % 4), ((i % 4) % 2) == 1, 4'b0000, "rr");
      end
      check("rr.valid_const", 32'(word_valid), 32'hF);
      check("rr.word_const", word, 32'hFF00FF00);
      applyStimulus(1'b0, 2'd0, 4'h0, 1'b0, 4'b1111, "rr_drain");

      // Overrun on lane 3, then a same-edge consume/refill.
      sendWord(2'd3, 8'hA5, 4'b0000, "ovr_a");
      sendWord(2'd3, 8'h3C, 4'b0000, "ovr_b");
      check("ovr.byte_kept", 32'(word[31:24]), 32'hA5);
      check("ovr.flag", 32'(overrun[3]), 32'h1);
      applyStimulus(1'b0, 2'd0, 4'h0, 1'b1, 4'b0000, "ovr_flush");
      sendWord(2'd3, 8'h3C, 4'b1000, "refill");
      check("refill.byte", 32'(word[31:24]), 32'h3C);
      check("refill.no_ovr", 32'(overrun[3]), 32'h0);
      applyStimulus(1'b0, 2'd0, 4'h0, 1'b0, 4'b1000, "refill_drain");

      // Stray Y bit on another lane still captures Y[S].
      applyStimulus(1'b1, 2'd2, 4'b0101, 1'b0, 4'b0000, "sel");
      check("sel.flag", 32'(sel_err), 32'h1);
      for (int i = 0; i < 7; i++) strobe(2'd2, 1'b0, 4'b0000, "sel_fill");
      check("sel.byte", 32'(word[23:16]), 32'h80);
      applyStimulus(1'b0, 2'd0, 4'h0, 1'b0, 4'b0100, "sel_drain");

      // Flush drops a partial word and clears sel_err.
      for (int i = 0; i < 3; i++) strobe(2'd0, 1'b1, 4'b0000, "fl_part");
      applyStimulus(1'b0, 2'd0, 4'h0, 1'b1, 4'b0000, "fl");
      check("fl.sel_clear", 32'(sel_err), 32'h0);
      for (int i = 0; i < 7; i++) strobe(2'd0, 1'b1, 4'b0000, "fl_seven");
      check("fl.not_yet", 32'(word_valid[0]), 32'h0);
      strobe(2'd0, 1'b0, 4'b0000, "fl_eighth");
      check("fl.done", 32'(word_valid[0]), 32'h1);
      check("fl.byte", 32'(word[7:0]), 32'hFE);
      applyStimulus(1'b0, 2'd0, 4'h0, 1'b0, 4'b0001, "fl_drain");

      // Flush and strobe together: that bit is discarded.
      applyStimulus(1'b1, 2'd1, 4'b0010, 1'b1, 4'b0000, "flstrb");
      sendWord(2'd1, 8'h00, 4'b0000, "flstrb_word");
      check("flstrb.byte", 32'(word[15:8]), 32'h00);
      check("flstrb.valid", 32'(word_valid[1]), 32'h1);

      // Random traffic with occasional stray bits, flushes and back-pressure.
      for (int i = 0; i < 600; i++) begin
         logic       st;
         logic [1:0] s;
         logic [3:0] y;
         st = ($urandom_range(0, 3) != 0);
         s  = 2'($urandom_range(0, 3));
         y  = 4'($urandom_range(0, 1)) << s;
         if ($urandom_range(0, 19) == 0) y = y ^ (4'b0001 << 2'($urandom_range(0, 3)));
         applyStimulus(st, s, y, $urandom_range(0, 39) == 0, 4'($urandom_range(0, 15)), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/demux_lane_deserializer.md
# demux_lane_deserializer

Sequential stage directly downstream of the 1-to-4 `demultiplexer`. Samples the demultiplexer outputs `Y[3:0]` together with the select `S[1:0]` that steered them, and collects the bits arriving on each lane into a per-lane WIDTH-bit word. Each lane presents completed words through an independent valid/ready handshake and flags words lost to back-pressure.

## Interface
- `WIDTH`, 8, bits per lane word; legal range 2..32.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `strb`  in  1  one demultiplexer bit is present this cycle on `Y[S]`.
- `S`  in  2  lane select, the same value that drives the demultiplexer.
- `Y`  in  4  demultiplexer outputs.
- `flush`  in  1  synchronous clear of all partial words and sticky flags.
- `word_ready`  in  4  per-lane consumer ready.
- `word_valid`  out  4  per-lane completed word available.
- `word`  out  4*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- `overrun`  out  4  per-lane sticky: a completed word was dropped.
- `sel_err`  out  1  sticky: on a `strb` cycle, a lane other than `S` had `Y` = 1.

## Operation
- Each lane k holds:
  - shift register `sh_k` (WIDTH bits);
  - bit counter `cnt_k` (0..WIDTH-1, width clog2(WIDTH));
  - output register `word_k`;
  - output state EMPTY/FULL, where FULL means `word_valid[k]`=1.
- Bit capture: on a `strb` cycle, lane `S` only:
  - `sh_S` <= {`sh_S`[WIDTH-2:0], `Y[S]`}, MSB first.
  - `cnt_S` increments.
  - Other lanes do not change.
- Word completion: `strb` with `cnt_S`==WIDTH-1.
  - `cnt_S` wraps to 0.
  - The completed word {`sh_S`[WIDTH-2:0], `Y[S]`} is offered to the output register.
  - The shift register contents are don't-care after a wrap, because the next word overwrites all WIDTH bits.
- Output state machine, per lane:
  - EMPTY + completion -> FULL, `word_k` loaded.
  - FULL + `word_ready[k]` -> EMPTY, unless a completion arrives the same cycle.
  - FULL + `word_ready[k]` + completion in the same cycle -> stays FULL, `word_k` loaded with the new word, no overrun.
  - FULL + completion without `word_ready[k]` -> new word dropped, `word_k` unchanged, `overrun[k]` set (sticky).
- `word_k` is stable while FULL and not consumed.
- `sel_err` is set if `strb`=1 and (`Y` & ~(4'b0001 << `S`)) != 0. Capture of `Y[S]` proceeds regardless.
- `flush`:
  - Clears all `cnt_k`, `overrun`, and `sel_err`.
  - Does not clear FULL output words.
  - Has priority over `strb` in the same cycle; that bit is discarded.
- With `strb`=0 there is no capture. `S` and `Y` are ignored.

## Timing
- Reset (`rst_n`=0, asynchronous) applies the following:
  - `word_valid`=4'b0000, `word`=0, `overrun`=4'b0000, `sel_err`=0.
  - All counters and shift registers are 0.
- Reset deasserted mid-word: the partial word is lost, and the next `strb` starts a new word at bit WIDTH-1.
- Latency: the completing `strb` is sampled at edge N; `word_valid[k]`=1 and `word` are valid after edge N. No combinational path from `strb`/`Y` to the outputs.
- A transfer occurs at an edge where `word_valid[k]`&&`word_ready[k]`. `word_valid[k]` falls after that edge unless it is refilled.
- `word_ready` may be high while `word_valid` is low; this has no effect.
- Back-to-back `strb` on every cycle is supported. Maximum aggregate rate is 1 bit/cycle; per-lane throughput is 1 word per WIDTH strobes.
- `overrun` and `sel_err` are set one edge after the causing cycle and hold until `flush` or reset.

## Test plan
- Reset and idle: assert `rst_n`=0 mid-run → all outputs 0 immediately, before any clock edge. Deassert, then hold `strb`=0 for 20 cycles → outputs unchanged.
- Single lane: `S`=2'b01, 8 strobes carrying `Y[1]` = 1,0,1,1,0,0,1,0 → `word_valid`=4'b0010 after the 8th edge, `word[15:8]`=8'hB2, other lanes untouched. `word_ready[1]`=1 for one cycle → `word_valid[1]` falls.
- Interleaved lanes: round-robin `S`=0,1,2,3 for 32 strobes, with lane k carrying constant bit (k odd) → after the last edge, `word_valid`=4'b1111 and words 00/FF/00/FF.
- Overrun: complete word 8'hA5 on lane 3 with `word_ready[3]`=0, then complete 8'h3C → `word[31:24]` stays 8'hA5 and `overrun[3]`=1. Repeat with `word_ready[3]`=1 on the completing edge → `word[31:24]`=8'h3C, no overrun.
- `sel_err` and `flush`:
  - `strb` with `S`=2, `Y`=4'b0101 → `sel_err`=1 and the captured bit is 1.
  - After 3 strobes on lane 0, assert `flush` → `sel_err`=0; lane 0 then needs a full 8 strobes to complete a word.
  - `flush` and `strb` in the same cycle → that bit is not captured.
